pipelined_subtractor: RTL and testbench



---
 rtl/sub_pkg.sv | 12 +
 rtl/pipelined_subtractor_if.sv | 26 ++
 rtl/sub_chunk_stage.sv | 74 +++++++
 rtl/pipelined_subtractor.sv | 77 +++++++
 tb/tb_pipelined_subtractor.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/sub_pkg.sv
// Shared constants and helpers for the pipelined subtractor.
package sub_pkg;

  localparam int unsigned SUB_CHUNK_DEFAULT = 4;

  // Number of pipeline stages; zero flags an unusable CHUNK.
  function automatic int unsigned sub_stages(input int unsigned width, input int unsigned chunk);
    if (chunk == 0) return 0;
    return width / chunk;
  endfunction

endpackage

// File: rtl/pipelined_subtractor_if.sv
// Valid/ready streaming bus for the pipelined subtractor (operands in, difference out).
interface pipelined_subtractor_if #(
  parameter int unsigned WIDTH = 16
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             borrow_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] difference;
  logic             borrow_out;

  modport master (
    output in_valid, a, b, borrow_in, out_ready,
    input  in_ready, out_valid, difference, borrow_out
  );

  modport slave (
    input  in_valid, a, b, borrow_in, out_ready,
    output in_ready, out_valid, difference, borrow_out
  );

endinterface

// File: rtl/sub_chunk_stage.sv
// One pipeline stage: subtracts the lowest remaining CHUNK slice and forwards the rest.
// Data layout (LSB first): finished result slices, remaining a bits, remaining b bits.
module sub_chunk_stage #(
  parameter int unsigned CHUNK = 4,
  parameter int unsigned REM_W = 16,
  parameter int unsigned WIDTH = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_valid,
  output logic                           o_ready_c,
  input  logic [WIDTH+REM_W-1:0]         i_data,
  input  logic                           i_borrow,
  output logic                           o_valid,
  input  logic                           i_ready,
  output logic [WIDTH+REM_W-CHUNK-1:0]   o_data,
  output logic                           o_borrow
);

  localparam int unsigned DONE_W = WIDTH - REM_W;
  localparam int unsigned PASS_W = REM_W - CHUNK;
  localparam int unsigned OW     = WIDTH + REM_W - CHUNK;

  logic             r_valid;
  logic [OW-1:0]    r_data;
  logic             r_borrow;

  logic [CHUNK-1:0] w_a_lo;
  logic [CHUNK-1:0] w_b_lo;
  logic [CHUNK-1:0] w_diff;
  logic             w_borrow;
  logic [OW-1:0]    w_next;

  assign w_a_lo = i_data[DONE_W +: CHUNK];
  assign w_b_lo = i_data[DONE_W+REM_W +: CHUNK];

  // Extra top bit of the widened subtraction is the slice borrow.
  assign {w_borrow, w_diff} = {1'b0, w_a_lo} - {1'b0, w_b_lo} - {{CHUNK{1'b0}}, i_borrow};

  // Result and a-bits keep their positions; upper b-bits shift down by one slice.
  if (PASS_W > 0) begin : g_pass
    always_comb begin
      w_next                         = OW'(i_data);
      w_next[DONE_W +: CHUNK]        = w_diff;
      w_next[DONE_W+REM_W +: PASS_W] = i_data[DONE_W+REM_W+CHUNK +: PASS_W];
    end
  end else begin : g_last
    always_comb begin
      w_next                  = OW'(i_data);
      w_next[DONE_W +: CHUNK] = w_diff;
    end
  end

  assign o_ready_c = !r_valid || i_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid  <= 1'b0;
      r_data   <= '0;
      r_borrow <= 1'b0;
    end else if (o_ready_c) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_data   <= w_next;
        r_borrow <= w_borrow;
      end
    end
  end

  assign o_valid  = r_valid;
  assign o_data   = r_data;
  assign o_borrow = r_borrow;

endmodule

// File: rtl/pipelined_subtractor.sv
// Pipelined WIDTH-bit subtractor a - b - borrow_in, one CHUNK slice per stage.
// Optional macro SUB_SATURATE_EN clamps the difference to zero on borrow.
module pipelined_subtractor
  import sub_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = SUB_CHUNK_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  pipelined_subtractor_if.slave  bus
);

  localparam int unsigned STAGES = sub_stages(WIDTH, CHUNK);

  if ((STAGES == 0) || (STAGES * CHUNK != WIDTH)) begin : g_bad_cfg
    $error("pipelined_subtractor: WIDTH must be a non-zero multiple of CHUNK");
  end

  logic [STAGES:0]  w_valid;
  logic [STAGES:0]  w_borrow;
  logic [WIDTH-1:0] w_res;

  assign w_valid[0]  = bus.in_valid;
  assign w_borrow[0] = bus.borrow_in;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned REM_W = WIDTH - CHUNK * k;

    logic [WIDTH+REM_W-1:0]       w_din;
    logic [WIDTH+REM_W-CHUNK-1:0] w_dout;
    logic                         w_rdy;
    logic                         w_rdy_nxt;

    if (k == 0) begin : g_head
      assign w_din = {bus.b, bus.a};
    end else begin : g_body
      assign w_din = g_stage[k-1].w_dout;
    end

    if (k == STAGES - 1) begin : g_tail
      assign w_rdy_nxt = bus.out_ready;
    end else begin : g_link
      assign w_rdy_nxt = g_stage[k+1].w_rdy;
    end

    sub_chunk_stage #(
      .CHUNK (CHUNK),
      .REM_W (REM_W),
      .WIDTH (WIDTH)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .i_valid   (w_valid[k]),
      .o_ready_c (w_rdy),
      .i_data    (w_din),
      .i_borrow  (w_borrow[k]),
      .o_valid   (w_valid[k+1]),
      .i_ready   (w_rdy_nxt),
      .o_data    (w_dout),
      .o_borrow  (w_borrow[k+1])
    );
  end

  assign w_res = g_stage[STAGES-1].w_dout;

  assign bus.in_ready   = g_stage[0].w_rdy;
  assign bus.out_valid  = w_valid[STAGES];
  assign bus.borrow_out = w_borrow[STAGES];

`ifdef SUB_SATURATE_EN
  assign bus.difference = w_borrow[STAGES] ? '0 : w_res;
`else
  assign bus.difference = w_res;
`endif

endmodule

// File: tb/tb_pipelined_subtractor.sv
// Randomized and directed bench for pipelined_subtractor against an arithmetic reference queue.
module tb_pipelined_subtractor;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned CHUNK  = 4;
  localparam int unsigned STAGES = WIDTH / CHUNK;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipelined_subtractor_if #(.WIDTH(WIDTH)) bus ();

  pipelined_subtractor #(
    .WIDTH (WIDTH),
    .CHUNK (CHUNK)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [WIDTH-1:0] diff;
    logic             bout;
    int               cyc;
    int               stalls;
  } exp_t;

  exp_t             q[$];
  int               n_checks  = 0;
  int               n_errors  = 0;
  int               cyc       = 0;
  int               stall_cnt = 0;
  int               n_emit    = 0;
  logic             acc;
  logic             obs_in_ready;
  logic             obs_out_valid;
  logic             obs_bout;
  logic [WIDTH-1:0] obs_diff;
  logic [WIDTH-1:0] last_diff;
  logic             last_bout;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Exact integer subtraction; borrow means the true result is negative.
  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bin);
    exp_t e;
    int   d;
    d      = int'(a) - int'(b) - int'(bin);
    e.bout = (d < 0);
    e.diff = d[WIDTH-1:0];
`ifdef SUB_SATURATE_EN
    if (e.bout) e.diff = '0;
`endif
    e.cyc    = cyc;
    e.stalls = stall_cnt;
    return e;
  endfunction

  function automatic logic [WIDTH-1:0] pick();
    case ($urandom % 6)
      0:       return '0;
      1:       return '1;
      2:       return WIDTH'(1);
      default: return WIDTH'($urandom);
    endcase
  endfunction

  // One clock: drive, observe, score any transfers, advance.
  task automatic cycle(input logic iv, input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                       input logic ibin, input logic ordy);
    exp_t e;
    bus.in_valid  = iv;
    bus.a         = ia;
    bus.b         = ib;
    bus.borrow_in = ibin;
    bus.out_ready = ordy;
    #1;
    obs_in_ready  = bus.in_ready;
    obs_out_valid = bus.out_valid;
    obs_diff      = bus.difference;
    obs_bout      = bus.borrow_out;
    acc           = iv && obs_in_ready;
    if (obs_out_valid && !ordy) stall_cnt++;
    if (obs_out_valid && q.size() == 0) begin
      check("spurious_out_valid", 32'(obs_out_valid), 32'd0);
    end else if (obs_out_valid && ordy) begin
      e = q.pop_front();
      check("diff", 32'(obs_diff), 32'(e.diff));
      check("bout", 32'(obs_bout), 32'(e.bout));
      if (e.stalls == stall_cnt) check("latency", 32'(cyc - e.cyc), 32'(STAGES));
      n_emit++;
      last_diff = obs_diff;
      last_bout = obs_bout;
    end
    if (acc) q.push_back(model(ia, ib, ibin));
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset(input int n);
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    cyc += n;
    rst = 1'b0;
    q.delete();
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_diff", 32'(bus.difference), 32'd0);
    check("rst_bout", 32'(bus.borrow_out), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 60 && q.size() > 0; i++) cycle(1'b0, '0, '0, 1'b0, 1'b1);
    check(tag, 32'(q.size()), 32'd0);
  endtask

  task automatic directed(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic bin, input logic [WIDTH-1:0] exp_diff, input logic exp_bout);
    int n0 = n_emit;
    cycle(1'b1, a, b, bin, 1'b1);
    check({tag, "_accept"}, 32'(acc), 32'd1);
    for (int i = 0; i < 10 && n_emit == n0; i++) cycle(1'b0, '0, '0, 1'b0, 1'b1);
    check({tag, "_emitted"}, 32'(n_emit - n0), 32'd1);
    check({tag, "_diff"}, 32'(last_diff), 32'(exp_diff));
    check({tag, "_bout"}, 32'(last_bout), 32'(exp_bout));
    check({tag, "_one_pulse"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    int               n0;
    int               n_acc;
    logic             held_ok;
    logic [WIDTH-1:0] held_diff;
    logic             held_bout;

    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.borrow_in = 1'b0;
    bus.out_ready = 1'b0;
    do_reset(2);

    directed("t1", 16'h1234, 16'h0034, 1'b0, 16'h1200, 1'b0);
`ifdef SUB_SATURATE_EN
    directed("t2_wrap", 16'h0000, 16'h0001, 1'b0, 16'h0000, 1'b1);
`else
    directed("t2_wrap", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1);
`endif
    directed("t3_ripple", 16'h1000, 16'h0FFF, 1'b1, 16'h0000, 1'b0);

    // Back-to-back burst: every item accepted, each with exact latency.
    n0 = n_emit;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, pick(), pick(), 1'($urandom % 2), 1'b1);
      check("b2b_accept", 32'(acc), 32'd1);
    end
    drain("b2b_drain");
    check("b2b_count", 32'(n_emit - n0), 32'd8);

    // Fill under a downstream stall; the pipe holds exactly STAGES items.
    n_acc   = 0;
    held_ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, pick(), pick(), 1'($urandom % 2), 1'b0);
      if (acc) n_acc++;
      if (i >= int'(STAGES)) check("full_in_ready", 32'(obs_in_ready), 32'd0);
      if (obs_out_valid) begin
        if (held_ok) begin
          check("stall_diff_stable", 32'(obs_diff), 32'(held_diff));
          check("stall_bout_stable", 32'(obs_bout), 32'(held_bout));
        end
        held_diff = obs_diff;
        held_bout = obs_bout;
        held_ok   = 1'b1;
      end
    end
    check("fill_accepted", 32'(n_acc), 32'(STAGES));
    drain("stall_drain");

    // Random traffic with random backpressure.
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom % 4 != 0), pick(), pick(), 1'($urandom % 2), 1'($urandom % 3 != 0));
    drain("rand_drain");

    // Reset with three items in flight; nothing may emerge afterwards.
    for (int i = 0; i < 3; i++) cycle(1'b1, pick(), pick(), 1'b0, 1'b1);
    do_reset(1);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, '0, '0, 1'b0, 1'b1);
      check("post_rst_out_valid", 32'(obs_out_valid), 32'd0);
    end
    directed("t_after_rst", 16'h8000, 16'h0001, 1'b1, 16'h7FFE, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
